// File: rtl/line_read_buffer.sv
// Single-line read buffer: serves 16-bit CPU reads from one held 128-bit line,
// refilling it from pmem on a miss and dropping it when the write path touches it.
module line_read_buffer #(
    parameter int unsigned TAG_W    = 12,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [TAG_W+OFFSET_W-1:0]         mem_address,
    input  logic                              mem_read,
    input  logic [1:0]                        mem_byte_enable,
    output logic [15:0]                       mem_rdata,
    output logic                              mem_resp,
    output logic [TAG_W+OFFSET_W-1:0]         pmem_address,
    output logic                              pmem_read,
    input  logic [(8 << OFFSET_W)-1:0]        pmem_rdata,
    input  logic                              pmem_resp,
    input  logic                              inv,
    input  logic [TAG_W+OFFSET_W-1:0]         inv_address
);

    localparam int unsigned ADDR_W = TAG_W + OFFSET_W;
    localparam int unsigned LINE_W = 8 << OFFSET_W;
    localparam int unsigned IDX_W  = OFFSET_W - 1;

    typedef enum logic [1:0] {StIdle, StFetch, StRespond} state_e;

    state_e              state_q;
    logic                valid_q;
    logic [TAG_W-1:0]    tag_q;
    logic [LINE_W-1:0]   line_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [1:0]          req_be_q;
    logic                abort_q;
    logic [15:0]         mem_rdata_q;
    logic                mem_resp_q;
    logic [ADDR_W-1:0]   pmem_address_q;
    logic                pmem_read_q;

    logic [TAG_W-1:0]    cpu_tag;
    logic [TAG_W-1:0]    inv_tag;
    logic [TAG_W-1:0]    req_tag;
    logic                inv_held;
    logic                inv_req;
    logic                hit;

    assign cpu_tag  = mem_address[ADDR_W-1:OFFSET_W];
    assign inv_tag  = inv_address[ADDR_W-1:OFFSET_W];
    assign req_tag  = req_addr_q[ADDR_W-1:OFFSET_W];
    assign inv_held = inv && (inv_tag == tag_q);
    assign inv_req  = inv && (inv_tag == req_tag);
    // A same-edge invalidate of the held line turns a would-be hit into a miss.
    assign hit      = valid_q && (tag_q == cpu_tag) && !inv_held;

    // Byte-granular offset bits below the word select never affect the result.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[0], inv_address[OFFSET_W-1:0], req_addr_q[0]};

    function automatic logic [15:0] extract(input logic [LINE_W-1:0] src,
                                            input logic [IDX_W-1:0]  idx,
                                            input logic [1:0]        be);
        logic [15:0] w;
        w = src[16*idx +: 16];
        return {be[1] ? w[15:8] : 8'h00, be[0] ? w[7:0] : 8'h00};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            valid_q        <= 1'b0;
            tag_q          <= '0;
            line_q         <= '0;
            req_addr_q     <= '0;
            req_be_q       <= '0;
            abort_q        <= 1'b0;
            mem_rdata_q    <= '0;
            mem_resp_q     <= 1'b0;
            pmem_address_q <= '0;
            pmem_read_q    <= 1'b0;
        end else begin
            if (inv_held) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    mem_resp_q     <= 1'b0;
                    pmem_read_q    <= 1'b0;
                    pmem_address_q <= '0;
                    if (mem_read) begin
                        req_addr_q <= mem_address;
                        req_be_q   <= mem_byte_enable;
                        if (hit) begin
                            mem_rdata_q <= extract(line_q, mem_address[OFFSET_W-1:1],
                                                   mem_byte_enable);
                            mem_resp_q  <= 1'b1;
                            state_q     <= StRespond;
                        end else begin
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {cpu_tag, {OFFSET_W{1'b0}}};
                            state_q        <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (inv_req) begin
                        abort_q <= 1'b1;
                    end
                    if (pmem_resp) begin
                        // The fill always installs; an abort only withholds validity.
                        line_q         <= pmem_rdata;
                        tag_q          <= req_tag;
                        valid_q        <= !(abort_q || inv_req);
                        abort_q        <= 1'b0;
                        pmem_read_q    <= 1'b0;
                        pmem_address_q <= '0;
                        if (mem_read) begin
                            mem_rdata_q <= extract(pmem_rdata, req_addr_q[OFFSET_W-1:1],
                                                   req_be_q);
                            mem_resp_q  <= 1'b1;
                            state_q     <= StRespond;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StRespond: begin
                    mem_resp_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_rdata    = mem_rdata_q;
    assign mem_resp     = mem_resp_q;
    assign pmem_address = pmem_address_q;
    assign pmem_read    = pmem_read_q;

endmodule
